// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink sequencer.
package blink_pkg;

    localparam int unsigned CNT_W = 26;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // One programmable blink step: half-period length and LED pattern.
    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [7:0]       pattern;
    } step_entry_t;

endpackage

// File: rtl/blink_sequencer_if.sv
// Control, configuration and status bundle of the blink sequencer.
interface blink_sequencer_if #(
    parameter int unsigned NUM_STEPS = 4,
    parameter int unsigned CNT_W     = blink_pkg::CNT_W
);
    localparam int unsigned STEP_W = $clog2(NUM_STEPS);

    logic              start;
    logic              stop;
    logic              hold;
    logic              loop_en;
    logic              cfg_we;
    logic [STEP_W-1:0] cfg_addr;
    logic [CNT_W-1:0]  cfg_period;
    logic [7:0]        cfg_pattern;

    logic [7:0]        LEDG;
    logic              busy;
    logic              done;
    logic [STEP_W-1:0] step_idx;
    logic              tick;

    // Board-side controller that drives commands and table writes.
    modport master (
        output start, stop, hold, loop_en,
        output cfg_we, cfg_addr, cfg_period, cfg_pattern,
        input  LEDG, busy, done, step_idx, tick
    );

    // Sequencer side.
    modport slave (
        input  start, stop, hold, loop_en,
        input  cfg_we, cfg_addr, cfg_period, cfg_pattern,
        output LEDG, busy, done, step_idx, tick
    );

endinterface

// File: rtl/tick_divider.sv
// Half-period divider: counts 0..max(period,1)-1 and flags the last count.
module tick_divider #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             CLOCK_50,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] period,
    output logic             wrap_c,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] last_c;

    // A zero period behaves as one, so the terminal count is then 0.
    always_comb begin
        last_c = (period == '0) ? '0 : period - CNT_W'(1);
    end

    // Next count; a period lowered below the current count runs to natural wrap.
    always_comb begin
        cnt_d  = cnt_q;
        wrap_c = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == last_c) begin
                wrap_c = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/blink_sequencer.sv
// Steps LEDG through a runtime-writable table of (half-period, pattern) steps.
module blink_sequencer #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned NUM_STEPS       = 4,
    parameter int unsigned CNT_W           = blink_pkg::CNT_W,
    parameter int unsigned BLINKS_PER_STEP = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset_n,
    blink_sequencer_if.slave   bus
);
    import blink_pkg::*;

    localparam int unsigned STEP_W    = $clog2(NUM_STEPS);
    localparam int unsigned BLINK_W   = $clog2(BLINKS_PER_STEP + 1);
    localparam int unsigned ENTRY_W   = blink_pkg::CNT_W;
    localparam int unsigned LAST_STEP = NUM_STEPS - 1;
    localparam int unsigned LAST_BLNK = BLINKS_PER_STEP - 1;

    seq_state_t         state_q, state_d;
    step_entry_t        table_q [NUM_STEPS];
    step_entry_t        table_d [NUM_STEPS];
    logic [STEP_W-1:0]  step_q, step_d;
    logic               phase_q, phase_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic [7:0]         ledg_q, ledg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               tick_q, tick_d;

    logic               div_clr_c;
    logic               div_en_c;
    logic               div_wrap_c;
    logic [CNT_W-1:0]   div_period_c;
    logic [CNT_W-1:0]   div_count;
    logic               unused_count_c;
    logic               last_blink_c;
    logic               last_step_c;

    // Divider runs only in RUN without hold/stop; it is held at zero elsewhere.
    assign div_en_c       = (state_q == RUN) && !bus.stop && !bus.hold;
    assign div_clr_c      = (state_q != RUN) || bus.stop;
    assign div_period_c   = CNT_W'(table_q[step_q].period);
    assign last_blink_c   = (blink_q == BLINK_W'(LAST_BLNK));
    assign last_step_c    = (step_q == STEP_W'(LAST_STEP));
    // Counter value is a debug observation point only.
    assign unused_count_c = ^div_count;

    tick_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .clr      (div_clr_c),
        .en       (div_en_c),
        .period   (div_period_c),
        .wrap_c   (div_wrap_c),
        .count    (div_count)
    );

    // Table write port; writes land at the edge and are seen live afterwards.
    always_comb begin
        table_d = table_q;
        if (bus.cfg_we) begin
            table_d[bus.cfg_addr].period  = ENTRY_W'(bus.cfg_period);
            table_d[bus.cfg_addr].pattern = bus.cfg_pattern;
        end
    end

    // Table storage with one-hot default patterns and half-second periods.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                table_q[i].period  <= ENTRY_W'(CLK_HZ / 2);
                table_q[i].pattern <= 8'(8'h01 << i);
            end
        end else begin
            table_q <= table_d;
        end
    end

    // Sequencer next-state: stop wins, then start in IDLE, blink stepping in RUN.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        phase_d = phase_q;
        blink_d = blink_q;
        ledg_d  = ledg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        tick_d  = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
            phase_d = 1'b0;
            blink_d = '0;
            ledg_d  = 8'h00;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = RUN;
                        step_d  = '0;
                        phase_d = 1'b1;
                        blink_d = '0;
                        ledg_d  = table_q[0].pattern;
                        busy_d  = 1'b1;
                    end
                end
                RUN: begin
                    if (!bus.hold) begin
                        if (div_wrap_c) begin
                            tick_d = 1'b1;
                            if (phase_q) begin
                                // Falling edge of the phase closes one blink.
                                phase_d = 1'b0;
                            end else if (!last_blink_c) begin
                                blink_d = blink_q + BLINK_W'(1);
                                phase_d = 1'b1;
                            end else begin
                                // Final blink done: move to the next step instead.
                                blink_d = '0;
                                phase_d = 1'b1;
                                if (last_step_c && !bus.loop_en) begin
                                    state_d = DONE;
                                    phase_d = 1'b0;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                    tick_d  = 1'b0;
                                end else begin
                                    step_d = step_q + STEP_W'(1);
                                end
                            end
                        end
                        if (state_d == RUN) begin
                            ledg_d = phase_d ? table_q[step_d].pattern : 8'h00;
                        end else begin
                            ledg_d = 8'h00;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    ledg_d  = 8'h00;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            phase_q <= 1'b0;
            blink_q <= '0;
            ledg_q  <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            phase_q <= phase_d;
            blink_q <= blink_d;
            ledg_q  <= ledg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign bus.LEDG     = ledg_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_idx = step_q;
    assign bus.tick     = tick_q;

endmodule

// File: tb/tb_blink_sequencer.sv
// Directed bench for blink_sequencer with a cycle-position reference model.
module tb_blink_sequencer;

    localparam int unsigned CLK_HZ    = 8;
    localparam int unsigned NUM_STEPS = 4;
    localparam int unsigned CNT_W     = 26;
    localparam int unsigned BPS       = 2;
    localparam int unsigned STEP_W    = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    blink_sequencer_if #(.NUM_STEPS(NUM_STEPS), .CNT_W(CNT_W)) bus ();

    blink_sequencer #(
        .CLK_HZ          (CLK_HZ),
        .NUM_STEPS       (NUM_STEPS),
        .CNT_W           (CNT_W),
        .BLINKS_PER_STEP (BPS)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Reference: position within the current step decides everything.
    int unsigned m_per [NUM_STEPS];
    logic [7:0]  m_pat [NUM_STEPS];
    int          m_state;   // 0 idle, 1 run, 2 done
    int unsigned m_step;
    int unsigned m_pos;
    logic [7:0]  m_led;
    logic        m_busy, m_done, m_tick;

    always @(posedge clk) begin : model
        int unsigned p;
        if (!reset_n) begin
            m_state = 0; m_step = 0; m_pos = 0;
            m_led = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_tick = 1'b0;
            for (int i = 0; i < int'(NUM_STEPS); i++) begin
                m_per[i] = CLK_HZ / 2;
                m_pat[i] = 8'h01 << i;
            end
        end else begin
            m_done = 1'b0;
            m_tick = 1'b0;
            if (bus.stop) begin
                m_state = 0; m_led = 8'h00; m_busy = 1'b0;
            end else begin
                case (m_state)
                    0: if (bus.start) begin
                        m_state = 1; m_step = 0; m_pos = 0;
                        m_led = m_pat[0]; m_busy = 1'b1;
                    end
                    1: if (!bus.hold) begin
                        p = (m_per[m_step] == 0) ? 1 : m_per[m_step];
                        m_pos = m_pos + 1;
                        m_tick = ((m_pos % p) == 0);
                        if (m_pos == 2 * BPS * p) begin
                            if (m_step == NUM_STEPS - 1 && !bus.loop_en) begin
                                m_state = 2; m_busy = 1'b0; m_done = 1'b1; m_tick = 1'b0;
                            end else begin
                                m_step = (m_step + 1) % NUM_STEPS;
                                m_pos = 0;
                            end
                        end
                        if (m_state != 1) m_led = 8'h00;
                        else m_led = (((m_pos / p) % 2) == 0) ? m_pat[m_step] : 8'h00;
                    end
                    default: m_state = 0;
                endcase
            end
            if (bus.cfg_we) begin
                m_per[bus.cfg_addr] = bus.cfg_period;
                m_pat[bus.cfg_addr] = bus.cfg_pattern;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if (bus.LEDG !== m_led || bus.busy !== m_busy || bus.done !== m_done ||
                bus.tick !== m_tick || bus.step_idx !== STEP_W'(m_step)) begin
                miscompares++;
                $display("FAIL model t=%0t got LEDG=%h busy=%b done=%b tick=%b step=%0d want LEDG=%h busy=%b done=%b tick=%b step=%0d",
                         $time, bus.LEDG, bus.busy, bus.done, bus.tick, bus.step_idx,
                         m_led, m_busy, m_done, m_tick, m_step);
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit(input string name, input logic [7:0] led, input logic b,
                       input logic d, input logic t, input logic [STEP_W-1:0] s);
        vectors++;
        if (bus.LEDG !== led || bus.busy !== b || bus.done !== d ||
            bus.tick !== t || bus.step_idx !== s) begin
            miscompares++;
            $display("FAIL %s got LEDG=%h busy=%b done=%b tick=%b step=%0d want LEDG=%h busy=%b done=%b tick=%b step=%0d",
                     name, bus.LEDG, bus.busy, bus.done, bus.tick, bus.step_idx, led, b, d, t, s);
        end
    endtask

    task automatic wr(input logic [STEP_W-1:0] a, input logic [CNT_W-1:0] per, input logic [7:0] pat);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_period = per; bus.cfg_pattern = pat;
        edges(1);
        bus.cfg_we = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0; bus.loop_en = 1'b0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_period = '0; bus.cfg_pattern = 8'h00;

        // Reset defaults, then start under hold freezes on default pattern 0.
        reset_n = 1'b0;
        edges(1);
        chk_en = 1'b1;
        edges(2);
        reset_n = 1'b1;
        edges(1);
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.start = 1'b1; bus.hold = 1'b1;
        edges(1);
        lit("start_hold", 8'h01, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.start = 1'b0;
        edges(3);
        lit("hold_frozen", 8'h01, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.stop = 1'b1;
        edges(1);
        lit("stop_hold", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.stop = 1'b0; bus.hold = 1'b0;

        // Basic run, no loop.
        wr(2'd0, 26'd3, 8'hA5);
        wr(2'd1, 26'd3, 8'h5A);
        wr(2'd2, 26'd3, 8'hF0);
        wr(2'd3, 26'd3, 8'h0F);
        bus.start = 1'b1;
        edges(1);
        lit("run_k0", 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.start = 1'b0;
        edges(3);
        lit("run_k3_off", 8'h00, 1'b1, 1'b0, 1'b1, 2'd0);
        edges(9);
        lit("run_k12_step1", 8'h5A, 1'b1, 1'b0, 1'b1, 2'd1);
        edges(36);
        lit("run_done", 8'h00, 1'b0, 1'b1, 1'b0, 2'd3);
        edges(1);
        lit("run_idle", 8'h00, 1'b0, 1'b0, 1'b0, 2'd3);

        // Loop with a zero period on step 1.
        wr(2'd1, 26'd0, 8'h5A);
        bus.loop_en = 1'b1;
        bus.start = 1'b1;
        edges(1);
        bus.start = 1'b0;
        edges(12);
        lit("loop_step1_on", 8'h5A, 1'b1, 1'b0, 1'b1, 2'd1);
        edges(1);
        lit("loop_step1_off", 8'h00, 1'b1, 1'b0, 1'b1, 2'd1);
        edges(27);
        lit("loop_wrap", 8'hA5, 1'b1, 1'b0, 1'b1, 2'd0);

        // Hold mid on-phase for 10 cycles.
        edges(1);
        bus.hold = 1'b1;
        edges(10);
        lit("hold_mid", 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.hold = 1'b0;
        edges(1);
        lit("hold_rel_on", 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        edges(1);
        lit("hold_rel_off", 8'h00, 1'b1, 1'b0, 1'b1, 2'd0);

        // Stop beats start, then restart.
        bus.stop = 1'b1; bus.start = 1'b1;
        edges(1);
        lit("stop_start", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        bus.stop = 1'b0;
        edges(1);
        lit("restart", 8'hA5, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.start = 1'b0;

        // Live pattern write, then reset mid step 1.
        wr(2'd2, 26'd3, 8'hFF);
        edges(15);
        lit("live_pattern", 8'hFF, 1'b1, 1'b0, 1'b1, 2'd2);
        edges(37);
        reset_n = 1'b0;
        edges(1);
        lit("reset_mid", 8'h00, 1'b0, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b1;

        // Defaults restored: reach step 2 and see its one-hot pattern.
        bus.loop_en = 1'b0;
        bus.start = 1'b1;
        edges(1);
        lit("default_k0", 8'h01, 1'b1, 1'b0, 1'b0, 2'd0);
        bus.start = 1'b0;
        edges(32);
        lit("default_step2", 8'h04, 1'b1, 1'b0, 1'b1, 2'd2);
        edges(40);
        lit("default_end", 8'h00, 1'b0, 1'b0, 1'b0, 2'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Controller that steps the green LEDs through a programmable table of blink steps.
- Each step is a (half-period, LED pattern) pair. A programmable tick divider times each half-period, and the FSM advances through the steps.
- Sits between board inputs (SW/KEY decode, driven by the top level) and LEDG.
- Shares one divider across all steps; table entries can be rewritten at runtime.

Parameters:
- CLK_HZ, 50000000, input clock frequency; sets the reset value of each period entry (CLK_HZ/2).
- NUM_STEPS, 4, table depth (power of 2, ≥2).
- CNT_W, 26, width of period entries and of the divider counter.
- BLINKS_PER_STEP, 2, full on/off blinks per step before advancing (≥1).

Ports:
- CLOCK_50, in, 1, single system clock; all logic on its rising edge.
- reset_n, in, 1, synchronous active-low reset.
- start, in, 1, level; sampled in IDLE to begin a sequence.
- stop, in, 1, level; aborts to IDLE from any state.
- hold, in, 1, level; freezes the divider, phase and step while in RUN.
- loop_en, in, 1, 1 = wrap from last step to step 0; 0 = finish via DONE.
- cfg_we, in, 1, table write strobe.
- cfg_addr, in, $clog2(NUM_STEPS), table entry index.
- cfg_period, in, CNT_W, half-period in CLOCK_50 cycles (0 is treated as 1).
- cfg_pattern, in, 8, LED pattern for the entry.
- LEDG, out, 8, registered LED drive.
- busy, out, 1, high in RUN.
- done, out, 1, one-cycle pulse in DONE.
- step_idx, out, $clog2(NUM_STEPS), current step.
- tick, out, 1, one-cycle pulse after each half-period boundary.

Behaviour:
- Reset (reset_n=0 at an edge):
  - State = IDLE.
  - LEDG, busy, done, tick, step_idx, counter, phase and blink count all = 0.
  - Table entry i: period = CLK_HZ/2, pattern = 8'h01<<i.
  - Reset mid-sequence aborts immediately; writes are ignored while reset_n=0.
- States: IDLE, RUN, DONE.
- IDLE → RUN on an edge with start=1 and stop=0:
  - step_idx ← 0, counter ← 0, phase ← 1, blink count ← 0.
  - LEDG ← pattern[0]; busy ← 1 on that same edge.
- RUN, hold=0:
  - Counter increments each cycle.
  - When counter == P-1 (P = max(period[step_idx],1)): counter ← 0, phase toggles, tick ← 1 next cycle.
  - LEDG = pattern when phase=1, otherwise 8'h00, updated on the same edge.
  - Each step therefore shows P cycles on, then P cycles off.
- Falling phase toggle (1→0) ends one blink. Blink count increments on the following rising toggle (0→1).
- Step advance happens when the blink count would reach BLINKS_PER_STEP:
  - Replaces that rising toggle; counter ← 0, blink count ← 0, phase ← 1.
  - step_idx ← step_idx+1, LEDG ← the new step's pattern.
- Last step:
  - loop_en=1: wraps to step 0.
  - loop_en=0: RUN → DONE (LEDG ← 0, busy ← 0, done ← 1 for one cycle), then DONE → IDLE.
- hold=1 in RUN: counter, phase, blink count, step and LEDG all frozen; tick=0. Hold is ignored in IDLE and DONE.
- stop=1 at any edge (RUN, DONE, IDLE) → IDLE, LEDG ← 0, busy ← 0, no done pulse.
  - stop has priority over start and hold when asserted together.
- Table writes:
  - cfg_we=1 writes entry cfg_addr at the edge, in any state except reset.
  - The period is read live from table[step_idx], so a write to the current step takes effect at the next compare.
  - Lowering the period below counter+1 causes the counter to run up to 2^CNT_W wrap. This is accepted behaviour; software must write the current step only while in IDLE or on hold.
  - The pattern is read live when LEDG is updated.
- tick is low except the one-cycle pulse described above; tick never asserts in IDLE or DONE.

Decomposition:
- Package blink_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t.
  - typedef struct {logic [CNT_W-1:0] period; logic [7:0] pattern;} step_entry_t.
  - Default constant CNT_W = 26.
- Sub-module tick_divider (~40 lines):
  - Inputs: CLOCK_50, reset_n, clr, en, period.
  - Outputs: a wrap pulse and the counter value.
  - Counts 0..max(period,1)-1 while en=1; clr forces 0.
- blink_sequencer holds the FSM, table, phase/blink counters and LED register.

Test Plan:
- Reset defaults: hold reset_n=0 for 3 cycles, release → LEDG=0, busy=0, step_idx=0; start=1 with hold=1 → LEDG=8'h01, busy=1, LEDG stays frozen.
- Basic run (BLINKS_PER_STEP=2, loop_en=0): write periods 3,3,3,3 and patterns A5,5A,F0,0F; start → LEDG A5 for 3 cycles, 00 for 3, A5 for 3, 00 for 3, then 5A. After step 3's second off-phase: done pulses 1 cycle, busy=0, LEDG=0.
- Loop and zero period: loop_en=1, period[1]=0 → step 1 toggles every cycle; after step 3, step_idx returns to 0 with LEDG=A5, no done pulse.
- Hold: hold=1 mid on-phase for 10 cycles → LEDG, step_idx and counter unchanged, tick=0; release → remaining on-phase cycles complete exactly (total 3 on-cycles).
- Stop and start: stop=1 with start=1 in the same cycle during RUN → IDLE, LEDG=0, no done; start alone next cycle → restart at step 0 with LEDG=A5.
- Reset and write during run: write step 2 pattern=FF while on step 0 → FF shown when step 2 is reached. reset_n=0 mid-step-1 → next cycle LEDG=0, IDLE, table back to defaults (pattern[2]=8'h04).
